vnu_ib_lut_page_loader: RTL and testbench
=========================================

Name: vnu_ib_lut_page_loader

Overview:
- Write-side sequencer directly upstream of the IB-VNU f1 datapath's symmetric LUT RAMs.
- Drives the datapath's page_addr_ram / ram_write_data_1 / ib_ram_we write port.
- On each iteration update, fetches all 2^ENTRY_ADDR pages of the iteration-specific IB LUT from an external fixed-latency ROM and replays them as RAM writes, then reports completion to the decoder controller.
- Pausable by the controller; abortable.

Parameters:
ENTRY_ADDR, 7, page address width; pages per load = 2^ENTRY_ADDR (MSB is the write_addr_offset bank select at the RAM).
LUT_PORT_SIZE, 4, bits per bank per page word.
BANK_NUM, 2, banks per page word; write data width = LUT_PORT_SIZE*BANK_NUM.
ITER_WIDTH, 5, width of iteration index.
ROM_LAT, 2, fixed ROM read latency in cycles (legal 1..4).

Ports:
write_clk  in  1  single clock (same domain as the RAM write port).
rst  in  1  synchronous, active-high reset.
load_start  in  1  1-cycle request to load LUT set for load_iter; honoured only in IDLE.
load_iter  in  ITER_WIDTH  iteration index, sampled with load_start.
load_pause  in  1  while high, no new ROM reads are issued.
load_abort  in  1  cancel the current load.
rom_en  out  1  ROM read strobe.
rom_addr  out  ITER_WIDTH+ENTRY_ADDR  {latched iter, page}.
rom_data  in  LUT_PORT_SIZE*BANK_NUM  valid exactly ROM_LAT cycles after rom_en.
page_addr_ram  out  ENTRY_ADDR  RAM write page address.
ram_write_data_1  out  LUT_PORT_SIZE*BANK_NUM  RAM write data; upper LUT_PORT_SIZE bits = bank0.
ib_ram_we  out  1  RAM write enable.
load_busy  out  1  high in FETCH/DRAIN.
load_done  out  1  1-cycle pulse on successful completion.
iter_loaded  out  ITER_WIDTH  iteration of last completed load.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, page counter 0, all pipeline valid bits cleared. Reset overrides every other input.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - load_start=1 latches load_iter, clears page counter, moves to FETCH next cycle.
  - load_abort in IDLE has no effect.
- FETCH:
  - Each cycle with load_pause=0: rom_en=1, rom_addr={iter,page}, page++.
  - After issuing page 2^ENTRY_ADDR-1, go to DRAIN; the counter wraps to 0 and is not reused.
  - load_pause=1: rom_en=0, counter held; in-flight reads still complete.
- Write pipeline:
  - ROM_LAT+1-stage shift register carries {valid, page}, aligned so rom_data is captured into a register.
  - ib_ram_we=1 exactly ROM_LAT+1 cycles after the matching rom_en, with page_addr_ram=that page and ram_write_data_1=captured rom_data.
  - Outputs are registered; when ib_ram_we=0, page_addr_ram and ram_write_data_1 hold their last values.
- DRAIN: no rom_en; exits to DONE the cycle after the last write is issued (pipeline empty).
- DONE:
  - load_done=1 for one cycle; iter_loaded updated in the same cycle.
  - Return to IDLE.
  - load_busy=0 in DONE and IDLE.
- load_start while busy is ignored; it is not queued.
- load_abort in FETCH or DRAIN:
  - Next cycle: FSM=IDLE, pipeline valid bits cleared, so no further ib_ram_we.
  - rom_en=0 that cycle.
  - No load_done; iter_loaded unchanged.
- Abort and start asserted together in IDLE: start wins. Abort and start together while busy: abort wins.
- Pause and abort asserted together: abort wins.
- Timing, unpaused, ROM_LAT=2, start at cycle 0:
  - rom_en cycles 1..128.
  - ib_ram_we cycles 4..131.
  - DRAIN cycles 129..131.
  - load_done cycle 132; load_busy cycles 1..131.
- Exactly 2^ENTRY_ADDR writes per completed load, one per page, in ascending page order, never duplicated.

Test Plan:
- Reset then load_start with load_iter=3, ROM model returns data=page[7:0] ^ 0x5A → 128 writes on cycles 4..131, page_addr_ram 0..127 in order, data matches; load_done only at cycle 132; iter_loaded=3.
- Pause held high during cycles 10..19 of FETCH → rom_en low for those 10 cycles; writes still total 128 with no gaps in address order; load_done delayed by 10 cycles (cycle 142).
- load_abort at cycle 50 → ib_ram_we never high after cycle 51; load_busy=0 from cycle 51; no load_done; iter_loaded keeps its previous value. A new load_start at cycle 55 then completes normally.
- load_start pulsed again at cycle 60 of an active load, with load_iter=7 → ignored; rom_addr upper bits stay at the original iter throughout.
- rst asserted mid-DRAIN → next cycle all outputs 0 and FSM IDLE; no load_done.
- Re-run the first scenario with ROM_LAT=1 and ROM_LAT=4 → first write at cycle 1+ROM_LAT+1; load_done at cycle 130+ROM_LAT.

Source files
------------

// File: rtl/vnu_ib_lut_page_loader.sv
// IB LUT page loader: streams every page of the iteration-specific IB LUT
// from a fixed-latency ROM into the f1 datapath's LUT RAM write port.
// Flow: IDLE -> FETCH (issue reads) -> DRAIN (flush in-flight reads) -> DONE.
module vnu_ib_lut_page_loader #(
    parameter int ENTRY_ADDR    = 7,
    parameter int LUT_PORT_SIZE = 4,
    parameter int BANK_NUM      = 2,
    parameter int ITER_WIDTH    = 5,
    parameter int ROM_LAT       = 2
) (
    input  logic                                write_clk,
    input  logic                                rst,
    input  logic                                load_start,
    input  logic [ITER_WIDTH-1:0]               load_iter,
    input  logic                                load_pause,
    input  logic                                load_abort,
    output logic                                rom_en,
    output logic [ITER_WIDTH+ENTRY_ADDR-1:0]    rom_addr,
    input  logic [LUT_PORT_SIZE*BANK_NUM-1:0]   rom_data,
    output logic [ENTRY_ADDR-1:0]               page_addr_ram,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0]   ram_write_data_1,
    output logic                                ib_ram_we,
    output logic                                load_busy,
    output logic                                load_done,
    output logic [ITER_WIDTH-1:0]               iter_loaded
);

    localparam int DW = LUT_PORT_SIZE * BANK_NUM;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [ITER_WIDTH-1:0]           iter_q, iter_d;
    logic [ENTRY_ADDR-1:0]           page_q, page_d;
    // Stage k holds the read issued k cycles ago; stage ROM_LAT lines up with rom_data.
    logic [ROM_LAT:1]                vld_pipe_q, vld_pipe_d;
    logic [ROM_LAT:1][ENTRY_ADDR-1:0] page_pipe_q, page_pipe_d;
    logic                            we_q, we_d;
    logic [ENTRY_ADDR-1:0]           wpage_q, wpage_d;
    logic [DW-1:0]                   wdata_q, wdata_d;
    logic [ITER_WIDTH-1:0]           iter_loaded_q, iter_loaded_d;

    logic busy;
    logic abort_hit;
    logic issue;

    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign abort_hit = load_abort && busy;
    // Abort outranks pause; a read is issued only when neither is active.
    assign issue     = (state_q == S_FETCH) && !load_pause && !load_abort;

    // State and datapath registers with synchronous reset
    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            iter_q        <= '0;
            page_q        <= '0;
            vld_pipe_q    <= '0;
            page_pipe_q   <= '0;
            we_q          <= 1'b0;
            wpage_q       <= '0;
            wdata_q       <= '0;
            iter_loaded_q <= '0;
        end else begin
            state_q       <= state_d;
            iter_q        <= iter_d;
            page_q        <= page_d;
            vld_pipe_q    <= vld_pipe_d;
            page_pipe_q   <= page_pipe_d;
            we_q          <= we_d;
            wpage_q       <= wpage_d;
            wdata_q       <= wdata_d;
            iter_loaded_q <= iter_loaded_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE and is never queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_start) state_d = S_FETCH;
            S_FETCH: begin
                if (load_abort)
                    state_d = S_IDLE;
                else if (issue && page_q == {ENTRY_ADDR{1'b1}})
                    state_d = S_DRAIN;
            end
            // Leave once no read is in flight; the last write is on the output this cycle.
            S_DRAIN: begin
                if (load_abort)
                    state_d = S_IDLE;
                else if (vld_pipe_q == '0)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Page counter, read pipeline and registered RAM write port
    always_comb begin
        iter_d        = iter_q;
        page_d        = page_q;
        iter_loaded_d = iter_loaded_q;

        if (state_q == S_IDLE && load_start) begin
            iter_d = load_iter;
            page_d = '0;
        end else if (issue) begin
            page_d = page_q + 1'b1;   // wraps to 0 after the last page; unused afterwards
        end

        vld_pipe_d     = '0;
        page_pipe_d    = page_pipe_q;
        vld_pipe_d[1]  = issue;
        page_pipe_d[1] = page_q;
        for (int k = 2; k <= ROM_LAT; k++) begin
            vld_pipe_d[k]  = vld_pipe_q[k-1];
            page_pipe_d[k] = page_pipe_q[k-1];
        end
        if (abort_hit)
            vld_pipe_d = '0;

        // Address/data hold their last value when no write is issued.
        we_d    = vld_pipe_q[ROM_LAT] && !abort_hit;
        wpage_d = vld_pipe_q[ROM_LAT] ? page_pipe_q[ROM_LAT] : wpage_q;
        wdata_d = vld_pipe_q[ROM_LAT] ? rom_data : wdata_q;

        if (state_q == S_DRAIN && state_d == S_DONE)
            iter_loaded_d = iter_q;
    end

    // Output decode
    always_comb begin
        rom_en           = issue;
        rom_addr         = {iter_q, page_q};
        page_addr_ram    = wpage_q;
        ram_write_data_1 = wdata_q;
        ib_ram_we        = we_q;
        load_busy        = busy;
        load_done        = (state_q == S_DONE);
        iter_loaded      = iter_loaded_q;
    end

endmodule

// File: tb/tb_vnu_ib_lut_page_loader.sv
// Bench for vnu_ib_lut_page_loader: three instances (ROM_LAT = 1, 2, 4) share
// the control inputs; each has its own ROM model returning page ^ 0x5A.
module tb_vnu_ib_lut_page_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_start = 1'b0, load_pause = 1'b0, load_abort = 1'b0;
    logic [4:0] load_iter = '0;

    logic [2:0]       rom_en_w, we_w, busy_w, done_w;
    logic [2:0][11:0] rom_addr_w;
    logic [2:0][7:0]  rom_data_w, wdata_w;
    logic [2:0][6:0]  page_w;
    logic [2:0][4:0]  itl_w;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vnu_ib_lut_page_loader #(.ROM_LAT(1)) u_l1 (
        .write_clk(clk), .rst(rst), .load_start(load_start), .load_iter(load_iter),
        .load_pause(load_pause), .load_abort(load_abort), .rom_en(rom_en_w[0]),
        .rom_addr(rom_addr_w[0]), .rom_data(rom_data_w[0]), .page_addr_ram(page_w[0]),
        .ram_write_data_1(wdata_w[0]), .ib_ram_we(we_w[0]), .load_busy(busy_w[0]),
        .load_done(done_w[0]), .iter_loaded(itl_w[0]));
    vnu_ib_lut_page_loader #(.ROM_LAT(2)) u_l2 (
        .write_clk(clk), .rst(rst), .load_start(load_start), .load_iter(load_iter),
        .load_pause(load_pause), .load_abort(load_abort), .rom_en(rom_en_w[1]),
        .rom_addr(rom_addr_w[1]), .rom_data(rom_data_w[1]), .page_addr_ram(page_w[1]),
        .ram_write_data_1(wdata_w[1]), .ib_ram_we(we_w[1]), .load_busy(busy_w[1]),
        .load_done(done_w[1]), .iter_loaded(itl_w[1]));
    vnu_ib_lut_page_loader #(.ROM_LAT(4)) u_l4 (
        .write_clk(clk), .rst(rst), .load_start(load_start), .load_iter(load_iter),
        .load_pause(load_pause), .load_abort(load_abort), .rom_en(rom_en_w[2]),
        .rom_addr(rom_addr_w[2]), .rom_data(rom_data_w[2]), .page_addr_ram(page_w[2]),
        .ram_write_data_1(wdata_w[2]), .ib_ram_we(we_w[2]), .load_busy(busy_w[2]),
        .load_done(done_w[2]), .iter_loaded(itl_w[2]));

    // ROM models: bit j of en_d holds rom_en from j+1 cycles ago
    logic [2:0][3:0]      en_d = '0;
    logic [2:0][3:0][6:0] pg_d = '0;
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            en_d[i] <= {en_d[i][2:0], rom_en_w[i]};
            pg_d[i] <= {pg_d[i][2:0], rom_addr_w[i][6:0]};
        end
    end
    assign rom_data_w[0] = en_d[0][0] ? ({1'b0, pg_d[0][0]} ^ 8'h5A) : 8'hC3;
    assign rom_data_w[1] = en_d[1][1] ? ({1'b0, pg_d[1][1]} ^ 8'h5A) : 8'hC3;
    assign rom_data_w[2] = en_d[2][3] ? ({1'b0, pg_d[2][3]} ^ 8'h5A) : 8'hC3;

    // Per-instance observation statistics, cycle numbers relative to t0
    bit mon_on = 1'b0;
    int t0 = 0, win_lo = -1, win_hi = -1, p_lo_g = -1, p_hi_g = -1;
    logic [4:0] mon_iter = '0;
    int wcnt[3], first_we[3], last_we[3], done_cyc[3], done_cnt[3], ord_err[3];
    int dat_err[3], en_cnt[3], en_pause[3], iter_err[3], busy_first[3], busy_last[3];
    int we_win[3], busy_win[3], itl_snap[3];

    always @(negedge clk) begin
        if (mon_on) begin
            int rc;
            rc = cyc - t0;
            for (int i = 0; i < 3; i++) begin
                if (rom_en_w[i]) begin
                    en_cnt[i]++;
                    if (rom_addr_w[i][11:7] != mon_iter) iter_err[i]++;
                    if (rc >= p_lo_g && rc <= p_hi_g) en_pause[i]++;
                end
                if (we_w[i]) begin
                    if (wcnt[i] == 0) first_we[i] = rc;
                    last_we[i] = rc;
                    if (page_w[i] != 7'(wcnt[i])) ord_err[i]++;
                    if (wdata_w[i] != ({1'b0, page_w[i]} ^ 8'h5A)) dat_err[i]++;
                    wcnt[i]++;
                    if (rc >= win_lo && rc <= win_hi) we_win[i]++;
                end
                if (done_w[i]) begin
                    if (done_cnt[i] == 0) done_cyc[i] = rc;
                    done_cnt[i]++;
                end
                if (busy_w[i]) begin
                    if (busy_first[i] < 0) busy_first[i] = rc;
                    busy_last[i] = rc;
                    if (rc >= win_lo && rc <= win_hi) busy_win[i]++;
                end
                if (rc == win_hi) itl_snap[i] = int'(itl_w[i]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One load: start at cycle 0 with optional pause window, abort, second start, reset
    task automatic run(input int it, input int p_lo, input int p_hi, input int ab_at,
                       input int s2_at, input int it2, input bit s2_acc,
                       input int w_lo, input int w_hi, input int rst_at, input int ncyc);
        for (int i = 0; i < 3; i++) begin
            wcnt[i] = 0; first_we[i] = -1; last_we[i] = -1; done_cyc[i] = -1;
            done_cnt[i] = 0; ord_err[i] = 0; dat_err[i] = 0; en_cnt[i] = 0;
            en_pause[i] = 0; iter_err[i] = 0; busy_first[i] = -1; busy_last[i] = -1;
            we_win[i] = 0; busy_win[i] = 0; itl_snap[i] = -1;
        end
        mon_iter = 5'(it); p_lo_g = p_lo; p_hi_g = p_hi; win_lo = w_lo; win_hi = w_hi;
        t0 = cyc; mon_on = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            load_start = (k == 0) || (k == s2_at);
            load_iter  = (k == s2_at) ? 5'(it2) : 5'(it);
            load_pause = (k >= p_lo) && (k <= p_hi);
            load_abort = (k == ab_at);
            rst        = (k == rst_at);
            if (k == s2_at && s2_acc) mon_iter = 5'(it2);
            @(posedge clk); #1;
        end
        load_start = 1'b0; load_pause = 1'b0; load_abort = 1'b0;
    endtask

    typedef struct {
        int it;
        int p_lo;
        int p_hi;
        int first[3];
        int done[3];
    } vec_t;

    vec_t vecs[2];

    initial begin
        // Unpaused load and a load paused over cycles 10..19 (pause adds 10 cycles)
        vecs[0] = '{it: 3, p_lo: -1, p_hi: -1, first: '{3, 4, 6}, done: '{131, 132, 134}};
        vecs[1] = '{it: 5, p_lo: 10, p_hi: 19, first: '{3, 4, 6}, done: '{141, 142, 144}};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_outs[%0d]", i),
                int'({rom_en_w[i], rom_addr_w[i], page_w[i], wdata_w[i], we_w[i],
                      busy_w[i], done_w[i], itl_w[i]}), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 2; v++) begin
            run(vecs[v].it, vecs[v].p_lo, vecs[v].p_hi, -1, -1, 0, 1'b0, -1, -1, -1, 150);
            mon_on = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("v%0d_wcnt[%0d]", v, i), wcnt[i], 128);
                chk($sformatf("v%0d_first_we[%0d]", v, i), first_we[i], vecs[v].first[i]);
                chk($sformatf("v%0d_last_we[%0d]", v, i), last_we[i], vecs[v].done[i] - 1);
                chk($sformatf("v%0d_done_cyc[%0d]", v, i), done_cyc[i], vecs[v].done[i]);
                chk($sformatf("v%0d_done_cnt[%0d]", v, i), done_cnt[i], 1);
                chk($sformatf("v%0d_order[%0d]", v, i), ord_err[i], 0);
                chk($sformatf("v%0d_data[%0d]", v, i), dat_err[i], 0);
                chk($sformatf("v%0d_en_cnt[%0d]", v, i), en_cnt[i], 128);
                chk($sformatf("v%0d_en_pause[%0d]", v, i), en_pause[i], 0);
                chk($sformatf("v%0d_iter_err[%0d]", v, i), iter_err[i], 0);
                chk($sformatf("v%0d_busy_first[%0d]", v, i), busy_first[i], 1);
                chk($sformatf("v%0d_busy_last[%0d]", v, i), busy_last[i], vecs[v].done[i] - 1);
                chk($sformatf("v%0d_iter_loaded[%0d]", v, i), int'(itl_w[i]), vecs[v].it);
                chk($sformatf("v%0d_hold_page[%0d]", v, i), int'(page_w[i]), 127);
                chk($sformatf("v%0d_hold_data[%0d]", v, i), int'(wdata_w[i]), 8'h25);
            end
        end

        // Abort at cycle 50, restart with iter 4 at cycle 55 (ROM_LAT=2 instance)
        run(9, -1, -1, 50, 55, 4, 1'b1, 51, 54, -1, 200);
        mon_on = 1'b0;
        chk("abort_we_after", we_win[1], 0);
        chk("abort_busy_after", busy_win[1], 0);
        chk("abort_iter_kept", itl_snap[1], 5);
        chk("abort_wcnt", wcnt[1], 47 + 128);
        chk("abort_done_cnt", done_cnt[1], 1);
        chk("abort_restart_done", done_cyc[1], 187);
        chk("abort_restart_iter", int'(itl_w[1]), 4);

        // Second start with iter 7 at cycle 60 must be ignored
        run(2, -1, -1, -1, 60, 7, 1'b0, -1, -1, -1, 150);
        mon_on = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("ign_iter_err[%0d]", i), iter_err[i], 0);
        chk("ign_wcnt", wcnt[1], 128);
        chk("ign_order", ord_err[1], 0);
        chk("ign_done_cyc", done_cyc[1], 132);
        chk("ign_iter_loaded", int'(itl_w[1]), 2);

        // Reset during DRAIN (cycle 130): cycle 131 shows all-zero outputs, no done
        run(6, -1, -1, -1, -1, 0, 1'b0, -1, -1, 130, 131);
        @(negedge clk);
        mon_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_drain_outs[%0d]", i),
                int'({rom_en_w[i], rom_addr_w[i], page_w[i], wdata_w[i], we_w[i],
                      busy_w[i], done_w[i], itl_w[i]}), 0);
            chk($sformatf("rst_drain_done_cnt[%0d]", i), done_cnt[i], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Start and abort together in IDLE: start wins; while busy: abort wins
        load_start = 1'b1; load_abort = 1'b1; load_iter = 5'd1;
        @(posedge clk); #1;
        load_start = 1'b0; load_abort = 1'b0;
        chk("idle_start_abort_busy", int'(busy_w[1]), 1);
        load_start = 1'b1; load_abort = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0; load_abort = 1'b0;
        chk("busy_start_abort_busy", int'(busy_w[1]), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_start_abort_we", int'(we_w[1]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
